// File: rtl/pc_pkg.sv
// Shared constants and next-PC select encoding for the PC / return-address-stack unit.
package pc_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [PC_W-1:0] TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_HOLD,
    SEL_REDIR,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: the oldest entry is overwritten when full.
module ras_stack #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign top_o   = empty_o ? '0 : mem_q[ptr_q];

  // Pointer/count next state; a push+pop on a non-empty stack rewrites the top in place.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push_i && pop_i && !empty_o) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
    end else if (push_i) begin
      ptr_d  = ptr_q + PTR_W'(1);
      wr_en  = 1'b1;
      wr_idx = ptr_q + PTR_W'(1);
      cnt_d  = full_o ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while the count hides them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with trap/stall/redirect/return selection and a return-address stack.
module pc_ras_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(pc_pkg::RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(pc_pkg::TRAP_VECTOR),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ret_miss,
  output logic            misalign
);

  import pc_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            ret_miss_q, ret_miss_d;
  pc_sel_e         sel;
  logic            active;
  logic            call_act;
  logic            ret_act;

  assign active   = !stall && !trap;
  assign call_act = call && active;
  assign ret_act  = ret && active;

  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign ret_miss = ret_miss_q;
  assign misalign = (pc_q[1:0] != 2'b00);

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst),
    .clear_i     (trap),
    .push_i      (call_act),
    .pop_i       (ret_act),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );

  // Next-PC priority select and return-miss detection.
  always_comb begin
    sel        = SEL_SEQ;
    pc_d       = pc_plus4;
    ret_miss_d = ret_act && ras_empty;
    if (trap) begin
      sel = SEL_TRAP;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (redirect_valid) begin
      sel = SEL_REDIR;
    end else if (ret_act && !ras_empty) begin
      sel = SEL_RAS;
    end
    case (sel)
      SEL_TRAP:  pc_d = TRAP_VECTOR;
      SEL_HOLD:  pc_d = pc_q;
      SEL_REDIR: pc_d = {redirect_target[XLEN-1:1], 1'b0};
      SEL_RAS:   pc_d = ras_top;
      default:   pc_d = pc_plus4;
    endcase
  end

  // PC and return-miss pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      ret_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ret_miss_q <= ret_miss_d;
    end
  end

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded at reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, PC value loaded on trap.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries; power of 2, >= 2.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port stall  input  1  hold PC and RAS.
REQ-008 SHALL have port trap  input  1  force PC to TRAP_VECTOR.
REQ-009 SHALL have port redirect_valid  input  1  taken branch or jump.
REQ-010 SHALL have port redirect_target  input  XLEN  branch or jump target.
REQ-011 SHALL have port call  input  1  current instruction is a call; push pc_plus4.
REQ-012 SHALL have port ret  input  1  current instruction is a return; pop RAS.
REQ-013 SHALL have port pc_out  output  XLEN  current PC, registered.
REQ-014 SHALL have port pc_plus4  output  XLEN  pc_out+4, combinational, modulo 2^XLEN.
REQ-015 SHALL have port ras_top  output  XLEN  top RAS entry; 0 when empty.
REQ-016 SHALL have port ras_empty / ras_full  output  1 each  RAS occupancy flags.
REQ-017 SHALL have port ret_miss  output  1  registered one-cycle pulse: ret executed with RAS empty.
REQ-018 SHALL have port misalign  output  1  combinational, pc_out[1:0] != 0.

Function
REQ-019 pc_out SHALL update only on rising clk; next-PC priority: trap > stall > redirect_valid > ret with RAS non-empty > pc_plus4.
REQ-020 Trap SHALL load TRAP_VECTOR, clear the RAS (count 0), and ignore call/ret in that cycle.
REQ-021 Stall without trap SHALL hold pc_out and all RAS state; call/ret ignored.
REQ-022 Redirect SHALL load {redirect_target[XLEN-1:1],1'b0}; bit 1 is kept, so misalign can assert.
REQ-023 Call/ret SHALL be "active" only when stall=0 and trap=0; active ret pops even when a redirect overrides the PC choice.
REQ-024 Active ret with RAS non-empty and no redirect SHALL load pc_out <= ras_top and decrement the count.
REQ-025 Active ret with RAS empty SHALL leave the RAS unchanged, take pc_plus4 (unless redirect), and pulse ret_miss next cycle.
REQ-026 Active call SHALL push pc_plus4; when full, SHALL overwrite the oldest entry (circular), with count saturating at RAS_DEPTH.
REQ-027 Active call and ret together SHALL replace the top with pc_plus4; count unchanged; PC takes old ras_top (or redirect); if empty, act as a push and pulse ret_miss.
REQ-028 The top pointer SHALL wrap modulo RAS_DEPTH on push and pop.
REQ-029 ras_full SHALL equal (count == RAS_DEPTH); ras_empty SHALL equal (count == 0).

Reset
REQ-030 rst low SHALL asynchronously force: pc_out=RESET_VECTOR, RAS count=0, top pointer=0, ret_miss=0; entries need not clear.
REQ-031 Reset deassertion SHALL take effect at the first rising clk with rst high; a reset mid-operation SHALL discard any in-flight push or pop.

Structure
REQ-032 A shared package (pc_pkg) SHALL hold the default constants RESET_VECTOR and TRAP_VECTOR and the next-PC-select enum {SEL_TRAP, SEL_HOLD, SEL_REDIR, SEL_RAS, SEL_SEQ}.
REQ-033 The RAS SHALL be one sub-module, ras_stack (storage, pointer, count, flags); the PC register and select logic SHALL stay in pc_ras_unit.

Verification
REQ-034 Reset then 3 free cycles -> pc_out 0x0, 0x4, 0x8, 0xC; misalign=0; ras_empty=1.
REQ-035 Call at pc 0x10 with redirect to 0x200, then ret at 0x204 -> pc_out 0x200, then 0x14; ras_empty=1 afterwards.
REQ-036 5 calls with RAS_DEPTH=4 at pcs 0x0,0x4,0x8,0xC,0x10 (no redirect), then 4 rets -> ras_full=1 after the 4th call; rets yield 0x14, 0x10, 0xC, 0x8.
REQ-037 Ret with RAS empty at pc 0x40 -> pc_out 0x44; ret_miss=1 for exactly one cycle.
REQ-038 Trap with stall, redirect, call and ret all high at pc 0x80 -> pc_out 0x100; RAS empty; stall alone next cycle -> pc_out holds at 0x100.
REQ-039 Redirect to 0x302 -> pc_out 0x302 and misalign=1; rst low mid-cycle -> pc_out 0x0 immediately, without waiting for clk.
